// File: rtl/video_timing_if.sv
// ----------------------------------------------------------------------------
// video_timing_if
// Raster timing bundle produced by video_timing_gen.
//   master : timing generator (drives every signal)
//   slave  : consumer (filter pipeline / line-buffer prefetch)
// Signals:
//   hsync, vsync      sync pulses at the generator's configured polarity
//   active            visible-area flag
//   x [XW], y [YW]    visible column/row, 0 outside the active area
//   line_start        one-ce pulse at x=0 of each visible line
//   frame_start       one-ce pulse at pixel (0,0)
//   frame_cnt [16]    frames completed (wrapping)
//   line_req          one-ce prefetch request for line req_line
//   req_line [YW]     line index, meaningful while line_req is high
// ----------------------------------------------------------------------------
interface video_timing_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          hsync;
    logic          vsync;
    logic          active;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic [15:0]   frame_cnt;
    logic          line_req;
    logic [YW-1:0] req_line;

    modport master (
        output hsync, vsync, active, x, y, line_start, frame_start,
               frame_cnt, line_req, req_line
    );

    modport slave (
        input  hsync, vsync, active, x, y, line_start, frame_start,
               frame_cnt, line_req, req_line
    );
endinterface

// File: rtl/video_timing_gen.sv
// ----------------------------------------------------------------------------
// video_timing_gen
// Parametrised raster timing generator. Free-running hcnt/vcnt counters
// (advanced on ce) are decoded into sync/active/coordinate/marker flags,
// which pass through 1+PIPE_DLY ce-qualified register stages so the raster
// outputs line up with the downstream filter pipeline. A separate,
// undelayed prefetch request (line_req/req_line) is raised LINE_LEAD pixels
// before each visible line starts.
// Ports:
//   pclk  in   pixel clock
//   rst   in   synchronous active-high reset (overrides ce)
//   ce    in   pixel enable; all state advances only when high
//   vif   master modport of video_timing_if carrying all timing outputs
// ----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int PIPE_DLY  = 0,
    parameter int LINE_LEAD = 32
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             ce,
    video_timing_if.master   vif
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int FCW     = 16;

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_VISIBLE);
    localparam logic [XW-1:0] HS_BEG   = XW'(H_VISIBLE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [XW-1:0] H_REQ    = XW'(H_TOTAL - LINE_LEAD);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT    = YW'(V_VISIBLE);
    localparam logic [YW-1:0] VS_BEG   = YW'(V_VISIBLE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [YW-1:0] V_REQMAX = YW'(V_VISIBLE - 1);
    localparam logic          HP       = HSYNC_POL[0];
    localparam logic          VP       = VSYNC_POL[0];

    // Sync flags are carried as "asserted" and converted to pin polarity
    // only after the last stage, so an all-zero vector is the idle state.
    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          act;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          ls;
        logic          fs;
    } rast_t;

    logic [XW-1:0]  r_hcnt;
    logic [YW-1:0]  r_vcnt;
    rast_t          w_dec;
    rast_t          w_stage_in [PIPE_DLY+1];
    rast_t          r_pipe     [PIPE_DLY+1];
    logic [FCW-1:0] r_frame_cnt;
    logic           r_line_req;
    logic [YW-1:0]  r_req_line;
    logic           w_req_hit;

    // Raster counters
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (ce) begin
            if (r_hcnt == H_LAST) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    // Stage-0 decode
    always_comb begin
        w_dec     = '0;
        w_dec.act = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
        w_dec.hs  = (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
        w_dec.vs  = (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);
        w_dec.x   = w_dec.act ? r_hcnt : '0;
        w_dec.y   = w_dec.act ? r_vcnt : '0;
        w_dec.ls  = w_dec.act && (r_hcnt == '0);
        w_dec.fs  = (r_hcnt == '0) && (r_vcnt == '0);
    end

    always_comb begin
        w_stage_in[0] = w_dec;
        for (int k = 1; k <= PIPE_DLY; k++)
            w_stage_in[k] = r_pipe[k-1];
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int k = 0; k <= PIPE_DLY; k++)
                r_pipe[k] <= '0;
        end else if (ce) begin
            for (int k = 0; k <= PIPE_DLY; k++)
                r_pipe[k] <= w_stage_in[k];
        end
    end

    // Counted as the frame_start pulse enters the output stage so the count
    // and the visible pulse change on the same ce edge.
    always_ff @(posedge pclk) begin
        if (rst)
            r_frame_cnt <= '0;
        else if (ce && w_stage_in[PIPE_DLY].fs)
            r_frame_cnt <= r_frame_cnt + 1'b1;
    end

    // Prefetch request: next line visible means either a visible line other
    // than the last follows, or the frame is about to wrap to line 0.
    assign w_req_hit = (r_hcnt == H_REQ) &&
                       ((r_vcnt < V_REQMAX) || (r_vcnt == V_LAST));

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_line_req <= 1'b0;
            r_req_line <= '0;
        end else if (ce) begin
            r_line_req <= w_req_hit;
            if (w_req_hit)
                r_req_line <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
        end
    end

    assign vif.hsync       = r_pipe[PIPE_DLY].hs ? HP : ~HP;
    assign vif.vsync       = r_pipe[PIPE_DLY].vs ? VP : ~VP;
    assign vif.active      = r_pipe[PIPE_DLY].act;
    assign vif.x           = r_pipe[PIPE_DLY].x;
    assign vif.y           = r_pipe[PIPE_DLY].y;
    assign vif.line_start  = r_pipe[PIPE_DLY].ls;
    assign vif.frame_start = r_pipe[PIPE_DLY].fs;
    assign vif.frame_cnt   = r_frame_cnt;
    assign vif.line_req    = r_line_req;
    assign vif.req_line    = r_req_line;
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator, successor to the fixed 640x480 sync block.
- Generates hsync/vsync, the active flag and x/y coordinates for any CEA/VESA-style mode. Adds programmable sync polarity, a pixel clock-enable, and a configurable output pipeline delay so the timing aligns with the downstream filter pipeline.
- Also emits frame/line markers and a line-prefetch request for the line buffer feeding the filter.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = negative pulse)
- VSYNC_POL, 0, asserted level of vsync
- PIPE_DLY, 0, extra ce-qualified register stages on all raster outputs (0..15)
- LINE_LEAD, 32, pixel lead of line_req ahead of the next visible line (1..H_FP+H_SYNC+H_BP)
- Derived localparams: H_TOTAL = sum of H terms; V_TOTAL = sum of V terms; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL); FCW = 16

Ports:
- pclk, in, 1, pixel clock
- rst, in, 1, synchronous active-high reset
- ce, in, 1, pixel enable; counters and pipeline advance only when high
- hsync, out, 1, horizontal sync at HSYNC_POL polarity
- vsync, out, 1, vertical sync at VSYNC_POL polarity
- active, out, 1, visible-area flag
- x, out, XW, visible column, 0 outside the active area
- y, out, YW, visible row, 0 outside the active area
- line_start, out, 1, one-ce pulse at x=0 of each visible line
- frame_start, out, 1, one-ce pulse at pixel (0,0)
- frame_cnt, out, 16, frames completed, wraps at 0xFFFF to 0
- line_req, out, 1, one-ce pulse requesting prefetch of line req_line
- req_line, out, YW, line index for line_req; valid while line_req is high

Behaviour:
- Reset: rst synchronous, active-high; clock pclk. rst overrides ce. After reset:
  - hcnt = vcnt = 0
  - every pipeline stage holds the inactive vector: hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, active = 0, x = y = 0, line_start = frame_start = line_req = 0
  - frame_cnt = 0, req_line = 0
- Counters, advanced on ce only:
  - hcnt counts 0..H_TOTAL-1 and wraps to 0.
  - On that wrap, vcnt increments, wrapping at V_TOTAL-1 to 0.
  - ce=0 freezes all state and outputs; pulses are held, not re-fired, so a pulse lasts exactly one ce-high cycle of observation.
- Stage-0 decode (combinational from hcnt/vcnt):
  - act0 = hcnt < H_VISIBLE and vcnt < V_VISIBLE
  - hs0 = hcnt in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC)
  - vs0 = vcnt in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC)
  - x0/y0 = hcnt/vcnt when act0, else 0
  - ls0 = act0 and hcnt == 0
  - fs0 = hcnt == 0 and vcnt == 0
- Output pipeline:
  - Stage-0 decode is registered once on ce, then passes through PIPE_DLY further ce-qualified stages.
  - Polarity is applied at the output register: hsync = hs ^ ~HSYNC_POL, likewise for vsync.
  - Latency from counter state to outputs is 1+PIPE_DLY ce-cycles. All raster outputs stay mutually aligned.
- frame_cnt increments in the same ce-cycle that frame_start asserts at the output; the first frame after reset counts as 0 -> 1.
- line_req / req_line:
  - Undelayed; registered once from counters.
  - Fires when hcnt == H_TOTAL-LINE_LEAD and the next line is visible. The next line is visible when vcnt < V_VISIBLE-1, with req_line = vcnt+1, or when vcnt == V_TOTAL-1, with req_line = 0.
  - No request for line V_VISIBLE or for any blanking line.
- Width rule: all comparisons use XW/YW unsigned; parameter sums are evaluated as 32-bit localparams.
- Wrap-around: at the frame wrap (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1) the next ce gives hcnt=vcnt=0 with no idle cycle.
- Reset mid-frame: next cycle matches the post-reset state exactly; the pipeline is flushed and no stale pulses emerge.

Test Plan:
- Defaults, ce=1, reset then run 2 frames:
  - hsync low for exactly 96 clocks per 800
  - vsync low for exactly 2 lines (1600 clocks) per 525 lines
  - active high for 640 clocks per line on 480 lines
  - frame_start period 420000 clocks; frame_cnt reads 2
- Defaults, first visible line: x steps 0..639 and then reads 0; y=0. line_start is high only at x=0. Output lags counter state by 1 clock.
- PIPE_DLY=3, HSYNC_POL=1, VSYNC_POL=1:
  - sync pulses are positive
  - all outputs shifted by exactly 3 extra clocks versus the PIPE_DLY=0 reference model
  - idle sync level after reset is 0
- ce toggling 1-of-4 cycles: outputs identical to the ce=1 sequence when sampled on ce cycles; frame period 1,680,000 clocks; no duplicate pulses.
- line_req with LINE_LEAD=32:
  - fires at hcnt=768 of line 524 with req_line=0, and of line 478 with req_line=479
  - does not fire on line 479 or lines 480..523
  - exactly 480 requests per frame
- Assert rst for 1 cycle mid-line (hcnt=300, vcnt=200) with PIPE_DLY=2: the next cycle shows the reset output vector; no pulse is seen for 3 cycles; the frame restarts at (0,0) and frame_cnt is 0.
